// File: rtl/cdh_reset_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cdh_reset_sequencer: SmartFusion2 fabric power-up / staged reset sequencer
// Revision: 1.0
// -----------------------------------------------------------------------------
module cdh_reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int LOCK_FILTER    = 256,
  parameter int STAGE_DELAY    = 1000,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int RETRY_DELAY    = 5000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                  CLK_BASE,
  input  logic                  RESET_N,
  input  logic                  CCC_LOCK,
  input  logic                  MSS_READY,
  input  logic                  INIT_DONE,
  input  logic                  SW_RESET_REQ,
  output logic                  FAB_RESET_N,
  output logic [NUM_STAGES-1:0] PERIPH_RESET_N,
  output logic                  SEQ_DONE,
  output logic                  FAULT,
  output logic [1:0]            FAULT_CODE,
  output logic [2:0]            RETRY_CNT
);

  localparam int CNT_MAX_A = (LOCK_FILTER > STAGE_DELAY) ? LOCK_FILTER : STAGE_DELAY;
  localparam int CNT_MAX_B = (TIMEOUT_CYCLES > RETRY_DELAY) ? TIMEOUT_CYCLES : RETRY_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int IW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STG_LAST  = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] RTY_LAST  = CW'(RETRY_DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD       = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_RELEASE    = 3'd2,
    S_WAIT_READY = 3'd3,
    S_STAGE      = 3'd4,
    S_RUN        = 3'd5,
    S_FAULT      = 3'd6
  } state_t;

  state_t          state;
  logic [CW-1:0]   tmo_cnt;
  logic [CW-1:0]   dly_cnt;
  logic [IW-1:0]   idx;
  logic            sw_prev;
  logic [3:0]      sync_meta;
  logic [3:0]      sync_q;
  logic            lock;
  logic            mss_ready;
  logic            init_done;
  logic            sw_req;
  logic            lock_lost;
  logic            timeout;
  logic            sw_edge;

  // Synchronisers run through reset so the request edge detector can be
  // preloaded with a settled level while RESET_N is low.
  always_ff @(posedge CLK_BASE) begin
    sync_meta <= {SW_RESET_REQ, INIT_DONE, MSS_READY, CCC_LOCK};
    sync_q    <= sync_meta;
  end

  assign {sw_req, init_done, mss_ready, lock} = sync_q;

  assign lock_lost = !lock && ((state == S_RELEASE) || (state == S_WAIT_READY) ||
                               (state == S_STAGE)   || (state == S_RUN));
  assign timeout   = ((state == S_WAIT_LOCK) || (state == S_WAIT_READY)) &&
                     (tmo_cnt == TMO_LAST);
  assign sw_edge   = sw_req && !sw_prev && (state != S_HOLD);

  always_ff @(posedge CLK_BASE) begin
    if (!RESET_N) begin
      state          <= S_HOLD;
      FAB_RESET_N    <= 1'b0;
      PERIPH_RESET_N <= '0;
      SEQ_DONE       <= 1'b0;
      FAULT          <= 1'b0;
      FAULT_CODE     <= 2'd0;
      RETRY_CNT      <= 3'd0;
      tmo_cnt        <= '0;
      dly_cnt        <= '0;
      idx            <= '0;
      sw_prev        <= sw_req;
    end else begin
      sw_prev <= sw_req;
      if (sw_edge && !lock_lost) begin
        state          <= S_WAIT_LOCK;
        FAB_RESET_N    <= 1'b0;
        PERIPH_RESET_N <= '0;
        SEQ_DONE       <= 1'b0;
        FAULT          <= 1'b0;
        RETRY_CNT      <= 3'd0;
        tmo_cnt        <= '0;
        dly_cnt        <= '0;
        idx            <= '0;
      end else if (lock_lost || timeout) begin
        state          <= S_FAULT;
        FAB_RESET_N    <= 1'b0;
        PERIPH_RESET_N <= '0;
        SEQ_DONE       <= 1'b0;
        FAULT          <= 1'b1;
        dly_cnt        <= '0;
        FAULT_CODE     <= lock_lost ? 2'd3 : ((state == S_WAIT_LOCK) ? 2'd1 : 2'd2);
      end else begin
        case (state)
          S_HOLD: begin
            state   <= S_WAIT_LOCK;
            tmo_cnt <= '0;
            dly_cnt <= '0;
          end
          S_WAIT_LOCK: begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (!lock) begin
              dly_cnt <= '0;
            end else if (dly_cnt == FILT_LAST) begin
              state       <= S_RELEASE;
              FAB_RESET_N <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            state   <= S_WAIT_READY;
            tmo_cnt <= '0;
          end
          S_WAIT_READY: begin
            if (mss_ready && init_done) begin
              state   <= S_STAGE;
              dly_cnt <= '0;
              idx     <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_STAGE: begin
            if (dly_cnt == STG_LAST) begin
              // Bits fill from bit 0 upward, so a shift-in releases the next stage.
              PERIPH_RESET_N <= (PERIPH_RESET_N << 1) | NUM_STAGES'(1);
              dly_cnt        <= '0;
              if (idx == IDX_LAST) begin
                state     <= S_RUN;
                SEQ_DONE  <= 1'b1;
                RETRY_CNT <= 3'd0;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              dly_cnt <= dly_cnt + 1'b1;
            end
          end
          S_RUN: begin
            state <= S_RUN;
          end
          S_FAULT: begin
            if (RETRY_CNT < RETRY_MAX) begin
              if (dly_cnt == RTY_LAST) begin
                state     <= S_WAIT_LOCK;
                FAULT     <= 1'b0;
                RETRY_CNT <= RETRY_CNT + 3'd1;
                tmo_cnt   <= '0;
                dly_cnt   <= '0;
              end else begin
                dly_cnt <= dly_cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= S_HOLD;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdh_reset_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cdh_reset_sequencer: scenario bench with arithmetic timing reference
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_cdh_reset_sequencer;

  localparam int NS = 4;
  localparam int LF = 4;
  localparam int SD = 8;
  localparam int TO = 100;
  localparam int RD = 16;
  localparam int MR = 2;

  localparam int W_FAB    = 0;
  localparam int W_FAULT1 = 1;
  localparam int W_FAULT0 = 2;
  localparam int W_DONE   = 3;
  localparam int W_PERIPH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lock = 1'b0;
  logic          mss = 1'b0;
  logic          init = 1'b0;
  logic          sw = 1'b0;
  logic          fab;
  logic [NS-1:0] periph;
  logic          done;
  logic          fault;
  logic [1:0]    code;
  logic [2:0]    rcnt;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  cdh_reset_sequencer #(
    .NUM_STAGES(NS), .LOCK_FILTER(LF), .STAGE_DELAY(SD),
    .TIMEOUT_CYCLES(TO), .RETRY_DELAY(RD), .MAX_RETRIES(MR)
  ) dut (
    .CLK_BASE(clk), .RESET_N(rst_n), .CCC_LOCK(lock), .MSS_READY(mss),
    .INIT_DONE(init), .SW_RESET_REQ(sw), .FAB_RESET_N(fab),
    .PERIPH_RESET_N(periph), .SEQ_DONE(done), .FAULT(fault),
    .FAULT_CODE(code), .RETRY_CNT(rcnt)
  );

  always #5 clk = ~clk;
  // After posedge number n, cyc reads n at the following negedge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit cond(input int sel, input logic [NS-1:0] val);
    case (sel)
      W_FAB:    return fab === 1'b1;
      W_FAULT1: return fault === 1'b1;
      W_FAULT0: return fault === 1'b0;
      W_DONE:   return done === 1'b1;
      W_PERIPH: return periph === val;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int sel, input logic [NS-1:0] val, input int budget,
                            output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cond(sel, val)) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset(output int r);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    r = cyc + 1;
  endtask

  task automatic test_reset();
    sw = 1'(($urandom) & 1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (fab !== 1'b0 || periph !== '0) begin
      n_fail++;
      $display("FAIL reset_resets: got fab=%b periph=%b, expected fab=0 periph=0000", fab, periph);
    end
    n_checks++;
    if (done !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got done=%b fault=%b, expected 0 0", done, fault);
    end
    n_checks++;
    if (code !== 2'd0 || rcnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_codes: got code=%0d rcnt=%0d, expected 0 0", code, rcnt);
    end
    sw = 1'b0;
  endtask

  task automatic test_nominal();
    int r, at, f, s, d1, d2, dm;
    bit ok;
    logic [NS-1:0] exp_v;
    for (int it = 0; it < 3; it++) begin
      lock = 1'b1; mss = 1'b0; init = 1'b0; sw = 1'b0;
      do_reset(r);
      wait_until(W_FAB, '0, 50, at, ok);
      n_checks++;
      if (!ok || at != r + LF) begin
        n_fail++;
        $display("FAIL nominal_fab_edge: got %0d (seen=%0b), expected %0d", at, ok, r + LF);
      end
      f  = at;
      d1 = (it == 0) ? 20 : int'($urandom_range(1, 40));
      d2 = (it == 0) ? 20 : int'($urandom_range(1, 40));
      dm = (d1 > d2) ? d1 : d2;
      for (int c = 1; c <= dm; c++) begin
        if (c == d1) mss = 1'b1;
        if (c == d2) init = 1'b1;
        if (c < dm) @(negedge clk);
      end
      s = f + dm + 2;
      for (int i = 0; i < NS; i++) begin
        exp_v = NS'((1 << (i + 1)) - 1);
        wait_until(W_PERIPH, exp_v, SD + 60, at, ok);
        n_checks++;
        if (!ok || at != s + SD * (i + 1)) begin
          n_fail++;
          $display("FAIL nominal_stage%0d_edge: got %0d (seen=%0b), expected %0d",
                   i, at, ok, s + SD * (i + 1));
        end
        n_checks++;
        if (done !== (i == NS - 1) || fab !== 1'b1) begin
          n_fail++;
          $display("FAIL nominal_stage%0d_flags: got done=%b fab=%b, expected done=%b fab=1",
                   i, done, fab, (i == NS - 1));
        end
      end
      n_checks++;
      if (fault !== 1'b0 || rcnt !== 3'd0 || code !== 2'd0) begin
        n_fail++;
        $display("FAIL nominal_run_status: got fault=%b rcnt=%0d code=%0d, expected 0 0 0",
                 fault, rcnt, code);
      end
    end
  endtask

  task automatic test_lock_glitch();
    int r, at, k2, g;
    bit ok;
    lock = 1'b0; mss = 1'b0; init = 1'b0; sw = 1'b0;
    do_reset(r);
    g = int'($urandom_range(2, 30));
    repeat (g) @(negedge clk);
    lock = 1'b1;
    repeat (3) @(negedge clk);
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    k2 = cyc + 1;
    wait_until(W_FAB, '0, 60, at, ok);
    n_checks++;
    if (!ok || at != k2 + 1 + LF) begin
      n_fail++;
      $display("FAIL glitch_fab_edge: got %0d (seen=%0b), expected %0d", at, ok, k2 + 1 + LF);
    end
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_no_fault: got fault=%b, expected 0", fault);
    end
  endtask

  task automatic test_lock_timeout();
    int r, at, t;
    bit ok;
    lock = 1'b0; mss = 1'b0; init = 1'b0; sw = 1'b0;
    do_reset(r);
    wait_until(W_FAULT1, '0, TO + 20, at, ok);
    n_checks++;
    if (!ok || at != r + TO || code !== 2'd1 || fab !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_timeout: got edge=%0d code=%0d fab=%b, expected edge=%0d code=1 fab=0",
               at, code, fab, r + TO);
    end
    t = at;
    wait_until(W_FAULT0, '0, RD + 10, at, ok);
    n_checks++;
    if (!ok || at != t + RD || rcnt !== 3'd1) begin
      n_fail++;
      $display("FAIL lock_timeout_retry: got edge=%0d rcnt=%0d, expected edge=%0d rcnt=1",
               at, rcnt, t + RD);
    end
  endtask

  task automatic test_ready_timeout();
    int r, at, f, t, x, k;
    bit ok;
    lock = 1'b1; mss = 1'b0; init = 1'b1; sw = 1'b0;
    do_reset(r);
    x = r;
    for (int a = 0; a <= MR; a++) begin
      wait_until(W_FAB, '0, 60, at, ok);
      n_checks++;
      if (!ok || at != x + LF) begin
        n_fail++;
        $display("FAIL rdy_to_fab_edge%0d: got %0d (seen=%0b), expected %0d", a, at, ok, x + LF);
      end
      f = at;
      wait_until(W_FAULT1, '0, TO + 20, at, ok);
      n_checks++;
      if (!ok || at != f + 1 + TO || code !== 2'd2 || fab !== 1'b0) begin
        n_fail++;
        $display("FAIL rdy_to_fault%0d: got edge=%0d code=%0d fab=%b, expected edge=%0d code=2 fab=0",
                 a, at, code, fab, f + 1 + TO);
      end
      t = at;
      if (a < MR) begin
        wait_until(W_FAULT0, '0, RD + 10, at, ok);
        n_checks++;
        if (!ok || at != t + RD || rcnt !== 3'(a + 1)) begin
          n_fail++;
          $display("FAIL rdy_to_retry%0d: got edge=%0d rcnt=%0d, expected edge=%0d rcnt=%0d",
                   a, at, rcnt, t + RD, a + 1);
        end
        x = at;
      end
    end
    wait_until(W_FAULT0, '0, 3 * RD, at, ok);
    n_checks++;
    if (ok || rcnt !== 3'(MR) || code !== 2'd2) begin
      n_fail++;
      $display("FAIL rdy_to_latched: got released=%0b rcnt=%0d code=%0d, expected released=0 rcnt=%0d code=2",
               ok, rcnt, code, MR);
    end
    sw = 1'b1;
    k = cyc + 1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_latency: got fault=%b one edge early, expected 1", fault);
    end
    @(negedge clk);
    n_checks++;
    if (fault !== 1'b0 || rcnt !== 3'd0 || code !== 2'd2 || fab !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_from_fault: got fault=%b rcnt=%0d code=%0d fab=%b, expected 0 0 2 0",
               fault, rcnt, code, fab);
    end
    wait_until(W_FAB, '0, 60, at, ok);
    n_checks++;
    if (!ok || at != k + 2 + LF) begin
      n_fail++;
      $display("FAIL sw_from_fault_fab: got %0d (seen=%0b), expected %0d", at, ok, k + 2 + LF);
    end
    sw = 1'b0;
  endtask

  task automatic test_lock_loss_run();
    int r, at, k, t, x, j, L, h, exp_f, first;
    bit ok;
    lock = 1'b1; mss = 1'b1; init = 1'b1; sw = 1'b0;
    do_reset(r);
    wait_until(W_DONE, '0, 200, at, ok);
    n_checks++;
    if (!ok || at != r + LF + 2 + SD * NS) begin
      n_fail++;
      $display("FAIL loss_reach_run: got %0d (seen=%0b), expected %0d", at, ok, r + LF + 2 + SD * NS);
    end
    h = int'($urandom_range(1, 20));
    repeat (h) @(negedge clk);
    lock = 1'b0;
    k = cyc + 1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_latency: got done=%b one edge early, expected 1", done);
    end
    @(negedge clk);
    t = k + 2;
    n_checks++;
    if (fab !== 1'b0 || periph !== '0 || done !== 1'b0 || fault !== 1'b1 || code !== 2'd3) begin
      n_fail++;
      $display("FAIL loss_fault: got fab=%b periph=%b done=%b fault=%b code=%0d, expected 0 0000 0 1 3",
               fab, periph, done, fault, code);
    end
    L = int'($urandom_range(1, RD + 20));
    x = -1;
    j = -1;
    for (int c = 1; c <= RD + 30; c++) begin
      if (c == L) begin
        lock = 1'b1;
        j = t + c;
      end
      @(negedge clk);
      if (x < 0 && fault === 1'b0) x = cyc;
      if (x >= 0 && c >= L) break;
    end
    n_checks++;
    if (x != t + RD || rcnt !== 3'd1) begin
      n_fail++;
      $display("FAIL loss_retry: got edge=%0d rcnt=%0d, expected edge=%0d rcnt=1", x, rcnt, t + RD);
    end
    first = ((x + 1) > (j + 2)) ? (x + 1) : (j + 2);
    exp_f = first + LF - 1;
    wait_until(W_FAB, '0, 80, at, ok);
    n_checks++;
    if (!ok || at != exp_f) begin
      n_fail++;
      $display("FAIL loss_refab: got %0d (seen=%0b), expected %0d", at, ok, exp_f);
    end
    wait_until(W_DONE, '0, 200, at, ok);
    n_checks++;
    if (!ok || at != exp_f + 2 + SD * NS || rcnt !== 3'd0 || code !== 2'd3 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_rerun: got edge=%0d rcnt=%0d code=%0d fault=%b, expected edge=%0d rcnt=0 code=3 fault=0",
               at, rcnt, code, fault, exp_f + 2 + SD * NS);
    end
  endtask

  task automatic test_sw_in_stage();
    int r, at, k;
    bit ok;
    lock = 1'b1; mss = 1'b1; init = 1'b1; sw = 1'b0;
    do_reset(r);
    wait_until(W_PERIPH, NS'(3), 200, at, ok);
    sw = 1'b1;
    k = cyc + 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok || periph !== '0 || fab !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_stage_clear: got seen=%0b periph=%b fab=%b done=%b fault=%b, expected 1 0000 0 0 0",
               ok, periph, fab, done, fault);
    end
    wait_until(W_FAB, '0, 60, at, ok);
    n_checks++;
    if (!ok || at != k + 2 + LF) begin
      n_fail++;
      $display("FAIL sw_stage_fab: got %0d (seen=%0b), expected %0d", at, ok, k + 2 + LF);
    end
    wait_until(W_DONE, '0, 200, at, ok);
    n_checks++;
    if (!ok || at != k + 2 + LF + 2 + SD * NS || periph !== '1) begin
      n_fail++;
      $display("FAIL sw_stage_rerun: got edge=%0d periph=%b, expected edge=%0d periph=1111",
               at, periph, k + 2 + LF + 2 + SD * NS);
    end
    sw = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_fall_ignored: got done=%b, expected 1", done);
    end
  endtask

  task automatic test_reset_mid_stage();
    int r, at, extra;
    bit ok;
    lock = 1'b1; mss = 1'b1; init = 1'b1; sw = 1'b0;
    do_reset(r);
    wait_until(W_PERIPH, NS'(1), 200, at, ok);
    extra = int'($urandom_range(0, 5));
    repeat (extra) @(negedge clk);
    lock = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sw = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!ok || fab !== 1'b0 || periph !== '0 || done !== 1'b0 || fault !== 1'b0 ||
        code !== 2'd0 || rcnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_wins: got seen=%0b fab=%b periph=%b done=%b fault=%b code=%0d rcnt=%0d, expected 1 0 0000 0 0 0 0",
               ok, fab, periph, done, fault, code, rcnt);
    end
    lock = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    r = cyc + 1;
    wait_until(W_FAB, '0, 60, at, ok);
    n_checks++;
    if (!ok || at != r + LF) begin
      n_fail++;
      $display("FAIL reset_sw_held_fab: got %0d (seen=%0b), expected %0d", at, ok, r + LF);
    end
    wait_until(W_DONE, '0, 200, at, ok);
    n_checks++;
    if (!ok || at != r + LF + 2 + SD * NS || fault !== 1'b0 || code !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_sw_held_run: got edge=%0d fault=%b code=%0d, expected edge=%0d fault=0 code=0",
               at, fault, code, r + LF + 2 + SD * NS);
    end
    sw = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t, expected summary before limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_lock_timeout();
    test_ready_timeout();
    test_lock_loss_run();
    test_sw_in_stage();
    test_reset_mid_stage();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
